// File: rtl/pwm_pkg.sv
// Shared constants and FSM encoding for the PWM duty-capture block.
package pwm_pkg;

  localparam int PERIOD = 16;
  localparam int DUTY_W = 4;
  localparam int CNT_W  = $clog2(2 * PERIOD + 1);

  typedef enum logic [1:0] {
    ARM,
    SEEK,
    MEAS,
    HOLD
  } state_t;

endpackage

// File: rtl/pwm_sync.sv
// Two-flop synchronizer for the PWM line, plus a delayed copy for rising-edge detection.
module pwm_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic lvl,
  output logic rise
);

  logic meta;
  logic prv;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      lvl  <= 1'b0;
      prv  <= 1'b0;
    end else begin
      meta <= async_in;
      lvl  <= meta;
      prv  <= lvl;
    end
  end

  assign rise = lvl & ~prv;

endmodule

// File: rtl/pwm_capture.sv
// Recovers the high time of a fixed-period PWM line; flags frame-length errors
// and a line that has stopped toggling.
module pwm_capture #(
  parameter int PERIOD = pwm_pkg::PERIOD,
  parameter int DUTY_W = pwm_pkg::DUTY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              perr,
  output logic              stuck
);

  import pwm_pkg::*;

  localparam int CP_W = $clog2(2 * PERIOD + 1);
  localparam logic [CP_W-1:0]   CP_ONE   = CP_W'(1);
  localparam logic [CP_W-1:0]   CP_FRAME = CP_W'(PERIOD);
  localparam logic [CP_W-1:0]   CP_LAST  = CP_W'(2 * PERIOD - 1);
  localparam logic [CP_W-1:0]   CP_MAX   = CP_W'(2 * PERIOD);
  localparam logic [DUTY_W-1:0] CH_ONE   = DUTY_W'(1);
  localparam logic [DUTY_W-1:0] CH_MAX   = '1;

  logic              lvl;
  logic              rise;
  state_t            state;
  logic [CP_W-1:0]   cp;
  logic [DUTY_W-1:0] ch;
  logic [1:0]        warm;

  pwm_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (pwm_in),
    .lvl      (lvl),
    .rise     (rise)
  );

  // warm gates ARM until the synchronizer holds real samples instead of its
  // reset zeros, so a line already high at reset is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARM;
      cp    <= '0;
      ch    <= '0;
      warm  <= '0;
      duty  <= '0;
      valid <= 1'b0;
      perr  <= 1'b0;
      stuck <= 1'b0;
    end else begin
      valid <= 1'b0;
      perr  <= 1'b0;
      if (warm != 2'd2) begin
        warm <= warm + 2'd1;
      end

      unique case (state)
        ARM: begin
          if (warm == 2'd2) begin
            if (!lvl) begin
              state <= SEEK;
            end else if (cp == CP_LAST) begin
              cp    <= CP_MAX;
              duty  <= CH_MAX;
              valid <= 1'b1;
              stuck <= 1'b1;
              state <= HOLD;
            end else begin
              cp <= cp + CP_ONE;
            end
          end
        end

        SEEK: begin
          if (rise) begin
            cp    <= CP_ONE;
            ch    <= CH_ONE;
            state <= MEAS;
          end
        end

        MEAS: begin
          if (rise) begin
            if (cp == CP_FRAME) begin
              duty  <= ch;
              valid <= 1'b1;
            end else begin
              perr <= 1'b1;
            end
            cp <= CP_ONE;
            ch <= CH_ONE;
          end else begin
            if (lvl && (ch != CH_MAX)) begin
              ch <= ch + CH_ONE;
            end
            // Two full periods without an edge: report the line as stuck at its level.
            if (cp == CP_LAST) begin
              cp    <= CP_MAX;
              duty  <= lvl ? CH_MAX : '0;
              valid <= 1'b1;
              stuck <= 1'b1;
              state <= HOLD;
            end else begin
              cp <= cp + CP_ONE;
            end
          end
        end

        HOLD: begin
          if (rise) begin
            stuck <= 1'b0;
            cp    <= CP_ONE;
            ch    <= CH_ONE;
            state <= MEAS;
          end
        end

        default: state <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a timestamp-based model of the capture rules is
// compared every cycle, with literal checkpoints pinning the model at key moments.
module tb_pwm_capture;

  localparam int PERIOD = 16;
  localparam int DUTY_W = 4;
  localparam int DMAX   = (1 << DUTY_W) - 1;
  localparam int HIST   = 2048;

  localparam int W_LOW  = 0;
  localparam int W_RISE = 1;
  localparam int LOCKED = 2;
  localparam int STK    = 3;

  logic              clk    = 1'b0;
  logic              rst    = 1'b1;
  logic              pwm_in = 1'b0;
  logic [DUTY_W-1:0] duty;
  logic              valid;
  logic              perr;
  logic              stuck;

  pwm_capture #(.PERIOD(PERIOD), .DUTY_W(DUTY_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .duty   (duty),
    .valid  (valid),
    .perr   (perr),
    .stuck  (stuck)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int edgeN       = 0;
  bit rstHist [HIST];
  bit lvlHist [HIST];
  bit prvHist [HIST];
  bit mS1 = 1'b0, mLvl = 1'b0, mPrv = 1'b0, lastPwm = 1'b0;
  int pwmRiseEdge = -100;

  int mode     = W_LOW;
  int lastRise = 0;
  int lastRst  = 0;
  int highRun  = 0;
  int expDuty  = 0;
  bit expValid = 1'b0, expPerr = 1'b0, expStuck = 1'b0;

  int validCount = 0;
  int perrCount  = 0;
  bit latCheck   = 1'b0;

  // Record, per clock edge, the synchronized level and its delayed copy as the
  // line definition gives them (reset clears the pipeline).
  initial forever begin
    @(posedge clk);
    mPrv = rst ? 1'b0 : mLvl;
    mLvl = rst ? 1'b0 : mS1;
    mS1  = rst ? 1'b0 : pwm_in;
    if (pwm_in && !lastPwm) pwmRiseEdge = edgeN;
    lastPwm = pwm_in;
    if (edgeN < HIST) begin
      rstHist[edgeN] = rst;
      lvlHist[edgeN] = mLvl;
      prvHist[edgeN] = mPrv;
    end
    edgeN++;
  end

  // Model: frames are judged from rise timestamps and a sum of high samples.
  initial forever begin
    int m, c, sum;
    bit lv, rs;
    @(negedge clk);
    if (edgeN > 0 && edgeN <= HIST) begin
      m = edgeN - 1;
      expValid = 1'b0;
      expPerr  = 1'b0;
      if (rstHist[m]) begin
        mode = W_LOW; highRun = 0; lastRst = m;
        expDuty = 0; expStuck = 1'b0;
      end else if (m >= 1) begin
        c  = m - 1;
        lv = lvlHist[c];
        rs = lv && !prvHist[c];
        case (mode)
          W_LOW: if (c - lastRst >= 2) begin
            if (!lv) mode = W_RISE;
            else begin
              highRun++;
              if (highRun == 2 * PERIOD) begin
                expDuty = DMAX; expValid = 1'b1; expStuck = 1'b1; mode = STK;
              end
            end
          end
          W_RISE: if (rs) begin lastRise = c; mode = LOCKED; end
          LOCKED: begin
            if (rs) begin
              if (c - lastRise == PERIOD) begin
                sum = 0;
                for (int k = lastRise; k < c; k++) if (lvlHist[k]) sum++;
                expDuty  = (sum > DMAX) ? DMAX : sum;
                expValid = 1'b1;
              end else begin
                expPerr = 1'b1;
              end
              lastRise = c;
            end else if (c - lastRise == 2 * PERIOD - 1) begin
              expDuty = lv ? DMAX : 0; expValid = 1'b1; expStuck = 1'b1; mode = STK;
            end
          end
          STK: if (rs) begin expStuck = 1'b0; lastRise = c; mode = LOCKED; end
          default: mode = W_LOW;
        endcase
      end

      vectors++;
      if ({duty, valid, perr, stuck} !== {DUTY_W'(expDuty), expValid, expPerr, expStuck}) begin
        miscompares++;
        $display("[TB] FAIL edge%0d outputs: got duty=%0d valid=%0b perr=%0b stuck=%0b, expected duty=%0d valid=%0b perr=%0b stuck=%0b",
                 m, duty, valid, perr, stuck, expDuty, expValid, expPerr, expStuck);
      end
      if (valid === 1'b1) validCount++;
      if (perr === 1'b1) perrCount++;
      if (latCheck && valid === 1'b1) begin
        vectors++;
        if (m - pwmRiseEdge + 1 != 3) begin
          miscompares++;
          $display("[TB] FAIL latency: got %0d cycles, expected 3", m - pwmRiseEdge + 1);
        end
      end
    end
  end

  task automatic applyStimulus(input int high, input int low, input int frames);
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < high; i++) begin @(negedge clk); pwm_in = 1'b1; end
      for (int i = 0; i < low; i++) begin @(negedge clk); pwm_in = 1'b0; end
    end
  endtask

  task automatic holdLevel(input bit level, input int n);
    repeat (n) begin @(negedge clk); pwm_in = level; end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    rst = 1'b1; pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;

    $display("[TB] 5/11 frames after reset release");
    applyStimulus(5, 11, 6);
    #1;
    checkOutput("s1 valids", validCount, 5);
    checkOutput("s1 perrs", perrCount, 0);
    checkOutput("s1 duty", int'(duty), 5);
    checkOutput("s1 model duty", expDuty, 5);

    $display("[TB] 15/1 frames with latency check");
    validCount = 0; perrCount = 0; latCheck = 1'b1;
    applyStimulus(15, 1, 6);
    #1;
    latCheck = 1'b0;
    checkOutput("s2 valids", validCount, 6);
    checkOutput("s2 duty", int'(duty), 15);
    checkOutput("s2 model duty", expDuty, 15);

    $display("[TB] lock at 7 then line held low");
    validCount = 0; perrCount = 0;
    applyStimulus(7, 9, 3);
    holdLevel(1'b0, 40);
    #1;
    checkOutput("s3 valids", validCount, 4);
    checkOutput("s3 duty", int'(duty), 0);
    checkOutput("s3 stuck", int'(stuck), 1);

    $display("[TB] recovery, then a short frame among duty-9 frames");
    validCount = 0; perrCount = 0;
    applyStimulus(9, 7, 1);
    #1;
    checkOutput("s4 stuck cleared", int'(stuck), 0);
    checkOutput("s4 no valid on recovery", validCount, 0);
    applyStimulus(9, 7, 2);
    applyStimulus(9, 3, 1);
    applyStimulus(9, 7, 2);
    #1;
    checkOutput("s4 valids", validCount, 4);
    checkOutput("s4 perrs", perrCount, 1);
    checkOutput("s4 duty", int'(duty), 9);

    $display("[TB] reset pulse mid-frame");
    validCount = 0; perrCount = 0;
    holdLevel(1'b1, 3);
    @(negedge clk); rst = 1'b1; pwm_in = 1'b1;
    @(negedge clk); rst = 1'b0; pwm_in = 1'b1;
    #1;
    checkOutput("s5 reset outputs", int'({duty, valid, perr, stuck}), 0);
    holdLevel(1'b1, 1);
    holdLevel(1'b0, 10);
    applyStimulus(6, 10, 1);
    #1;
    checkOutput("s5 valids before lock", validCount, 1);
    applyStimulus(6, 10, 2);
    #1;
    checkOutput("s5 valids", validCount, 3);
    checkOutput("s5 perrs", perrCount, 0);
    checkOutput("s5 duty", int'(duty), 6);

    $display("[TB] line held high through reset");
    validCount = 0; perrCount = 0;
    @(negedge clk); rst = 1'b1; pwm_in = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk); rst = 1'b0;
    holdLevel(1'b1, 31);
    #1;
    checkOutput("s6 quiet window", validCount, 0);
    holdLevel(1'b1, 9);
    #1;
    checkOutput("s6 valids", validCount, 1);
    checkOutput("s6 duty", int'(duty), 15);
    checkOutput("s6 stuck", int'(stuck), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter PERIOD, default 16, meaning PWM frame length in CLK cycles expected on the input.
REQ-002 Parameter DUTY_W, default 4, meaning width of the recovered duty word.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 PWM_IN  input  1  asynchronous PWM line, high-first frames from a PERIOD-cycle generator.
REQ-006 DUTY  output  DUTY_W  last recovered high-time in cycles, held between updates.
REQ-007 VALID  output  1  one-cycle strobe, DUTY updated this cycle.
REQ-008 PERR  output  1  one-cycle strobe, measured frame length not equal to PERIOD.
REQ-009 STUCK  output  1  level, line constant for 2*PERIOD cycles; cleared on next rising edge.

Function
REQ-010 PWM_IN shall pass a 2-flop synchronizer; the synchronized level LVL and its one-cycle-delayed copy PRV shall drive all logic; RISE = LVL & ~PRV.
REQ-011 The FSM shall have states ARM, SEEK, MEAS, HOLD.
REQ-012 ARM: go to SEEK when LVL=0; if LVL stays 1 for 2*PERIOD cycles, set DUTY=all-ones, pulse VALID, set STUCK, go to HOLD.
REQ-013 SEEK: on RISE load period count CP=1, high count CH=1, go to MEAS; no output strobe.
REQ-014 MEAS, no RISE: CP += 1; CH += LVL.
REQ-015 MEAS, RISE with CP == PERIOD: DUTY <= CH (truncated to DUTY_W), pulse VALID, reload CP=1, CH=1, stay in MEAS.
REQ-016 MEAS, RISE with CP != PERIOD: pulse PERR, DUTY unchanged, no VALID, reload CP=1, CH=1, stay in MEAS.
REQ-017 MEAS, CP reaches 2*PERIOD without RISE: if LVL=0 set DUTY=0, else set DUTY=all-ones; pulse VALID; set STUCK; go to HOLD.
REQ-018 HOLD: counters frozen; on RISE clear STUCK, load CP=1, CH=1, go to MEAS.
REQ-019 CH shall saturate at all-ones of DUTY_W; CP shall saturate at 2*PERIOD; neither shall wrap.
REQ-020 Latency: VALID shall assert 3 CLK cycles after the PWM_IN rising edge that closes the frame (2 sync + 1 register).
REQ-021 VALID and PERR shall never assert in the same cycle.
REQ-022 A high time of PERIOD-1 (generator input 15) shall decode as DUTY=15; a line held low shall decode as DUTY=0 via REQ-017.

Reset
REQ-023 On RST: sync flops, PRV, CP, CH = 0; DUTY = 0; VALID = PERR = STUCK = 0; state = ARM.
REQ-024 RST asserted mid-frame shall discard the partial measurement with no strobe; the first frame after reset shall not produce VALID.

Structure
REQ-025 Package pwm_pkg shall hold PERIOD, DUTY_W, counter width CNT_W = clog2(2*PERIOD+1) = 6, and the FSM state enumeration.
REQ-026 Sub-module pwm_sync (2-flop synchronizer + PRV register + RISE output) shall be instantiated once; the FSM and counters reside in pwm_capture.

Verification
REQ-027 Frames of 5 high / 11 low, RST released at t=100 ns -> after the second rising edge, VALID once per 16 cycles with DUTY=5, PERR never.
REQ-028 Frames of 15 high / 1 low -> DUTY=15 each frame, VALID 3 cycles after each PWM_IN rise.
REQ-029 Line held 0 after lock at DUTY=7 -> 32 cycles after the last rise, VALID with DUTY=0 and STUCK=1; the next rise clears STUCK with no VALID.
REQ-030 Line held 1 through reset release -> no VALID for 31 cycles; on cycle 32 of high LVL, VALID with DUTY=15 and STUCK=1.
REQ-031 One 12-cycle frame inserted between 16-cycle frames of duty 9 -> single PERR, DUTY stays 9, next 16-cycle frame gives VALID with DUTY=9.
REQ-032 RST pulsed 1 cycle mid-frame -> all outputs 0 next cycle, no strobe until two full frames have passed.
